// File: rtl/byte_sat_pkg.sv
// Shared types and constants for the lane-serial packed saturating add/subtract unit.
package byte_sat_pkg;

  localparam int LANE_W = 8;
  localparam logic [LANE_W-1:0] SAT_MAX = 8'h7F;
  localparam logic [LANE_W-1:0] SAT_MIN = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/byte_sat_lane.sv
// Single signed-byte lane: saturating add/subtract plus raw unsigned carry out.
module byte_sat_lane
  import byte_sat_pkg::*;
(
  input  logic [LANE_W-1:0] x,
  input  logic [LANE_W-1:0] y,
  input  logic              sub,
  output logic [LANE_W-1:0] r,
  output logic              cout,
  output logic              sat
);

  logic [LANE_W:0]   e_s;
  logic [LANE_W:0]   carry_s;
  logic [LANE_W-1:0] y_op_s;

  // Exact 9-bit signed result; its top two bits disagree exactly when the byte range is exceeded.
  always_comb begin
    e_s     = 9'd0;
    y_op_s  = 8'd0;
    carry_s = 9'd0;
    r       = 8'd0;
    cout    = 1'b0;
    sat     = 1'b0;
    if (sub) begin
      e_s    = {x[7], x} - {y[7], y};
      y_op_s = ~y;
    end else begin
      e_s    = {x[7], x} + {y[7], y};
      y_op_s = y;
    end
    carry_s = {1'b0, x} + {1'b0, y_op_s} + {8'd0, sub};
    cout    = carry_s[8];
    if (e_s[8:7] == 2'b01) begin
      r   = SAT_MAX;
      sat = 1'b1;
    end else if (e_s[8:7] == 2'b10) begin
      r   = SAT_MIN;
      sat = 1'b1;
    end else begin
      r   = e_s[7:0];
      sat = 1'b0;
    end
  end

endmodule

// File: rtl/byte_sat_seq.sv
// Lane-serial packed saturating add/subtract, one byte lane per cycle, low lane first.
// Optional sticky saturation flags are built when BYTE_SAT_STICKY_EN is defined.
module byte_sat_seq
  import byte_sat_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANE_W*LANES-1:0] a,
  input  logic [LANE_W*LANES-1:0] b,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANE_W*LANES-1:0] result,
  output logic [LANES-1:0]        cout,
  output logic [LANES-1:0]        sat
`ifdef BYTE_SAT_STICKY_EN
  ,
  input  logic                    clr_sticky,
  output logic [LANES-1:0]        sticky_sat
`endif
);

  localparam int W     = LANE_W * LANES;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_e             state_r;
  state_e             state_s;
  logic [IDX_W-1:0]   idx_r;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic               sub_r;
  logic [LANE_W-1:0]  lane_x_s;
  logic [LANE_W-1:0]  lane_y_s;
  logic [LANE_W-1:0]  lane_r_s;
  logic               lane_cout_s;
  logic               lane_sat_s;
  logic               last_lane_s;

  // Select the operand bytes of the lane currently being computed.
  always_comb begin
    lane_x_s    = a_r[int'(idx_r)*LANE_W +: LANE_W];
    lane_y_s    = b_r[int'(idx_r)*LANE_W +: LANE_W];
    last_lane_s = (idx_r == IDX_W'(LANES - 1));
  end

  byte_sat_lane u_lane (
    .x    (lane_x_s),
    .y    (lane_y_s),
    .sub  (sub_r),
    .r    (lane_r_s),
    .cout (lane_cout_s),
    .sat  (lane_sat_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (last_lane_s) state_s = DONE;
        else             state_s = CALC;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Operand capture, per-lane result write-back and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= '0;
      sat       <= '0;
      idx_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
    end else begin
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            sub_r <= sub;
            idx_r <= '0;
          end
        end
        CALC: begin
          result[int'(idx_r)*LANE_W +: LANE_W] <= lane_r_s;
          cout[idx_r] <= lane_cout_s;
          sat[idx_r]  <= lane_sat_s;
          if (!last_lane_s) idx_r <= idx_r + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BYTE_SAT_STICKY_EN
  logic [LANES-1:0] sticky_set_s;

  // Lane that saturates this cycle, as a one-hot mask.
  always_comb begin
    sticky_set_s = '0;
    if (state_r == CALC && lane_sat_s) sticky_set_s = LANES'(1) << idx_r;
    else                               sticky_set_s = '0;
  end

  // Sticky flags: a set in the same cycle as a clear survives it.
  always_ff @(posedge clk) begin
    if (rst)             sticky_sat <= '0;
    else if (clr_sticky) sticky_sat <= sticky_set_s;
    else                 sticky_sat <= sticky_sat | sticky_set_s;
  end
`endif

endmodule
